// File: rtl/adc_pattern_pkg.sv
// Shared types and constants for the ADC test-pattern generator:
// pattern modes, sequencer states and the PN23 polynomial/seed.
package adc_pattern_pkg;

  typedef enum logic [2:0] {
    MODE_ZERO    = 3'd0,
    MODE_RAMP    = 3'd1,
    MODE_CHECKER = 3'd2,
    MODE_PN23    = 3'd3,
    MODE_FIXED   = 3'd4
  } mode_t;

  typedef enum logic [1:0] {
    IDLE,
    SYNC_WAIT,
    RUN
  } state_t;

  localparam int          PN_LEN    = 23;
  localparam int          PN_TAP_HI = 22;
  localparam int          PN_TAP_LO = 17;
  localparam logic [22:0] PN_SEED   = 23'h7FFFFF;

  // Checker words, LSB first: the first word has bit 0 clear, bit 1 set, ...
  localparam logic [15:0] CHK_FIRST  = 16'hAAAA;
  localparam logic [15:0] CHK_SECOND = 16'h5555;

  // One Fibonacci shift of x^23 + x^18 + 1
  function automatic logic [PN_LEN-1:0] pn_step(input logic [PN_LEN-1:0] s);
    return {s[PN_LEN-2:0], s[PN_TAP_HI] ^ s[PN_TAP_LO]};
  endfunction

endpackage

// File: rtl/adc_pattern_ch.sv
// Single-channel pattern source. The sample is combinational from the
// (optionally reseeded) generator state; the top registers it.
module adc_pattern_ch
  import adc_pattern_pkg::*;
#(
  parameter int DATA_W    = 14,
  parameter int CH_IDX    = 0,
  parameter int CH_OFFSET = 2**(DATA_W-2)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        mode,
  input  logic              reseed,
  input  logic              step,
  input  logic [DATA_W-1:0] fixed_word,
  output logic [DATA_W-1:0] sample
);

  localparam int                RAMP_SEED_INT = CH_IDX * CH_OFFSET;
  localparam logic [DATA_W-1:0] RAMP_SEED     = RAMP_SEED_INT[DATA_W-1:0];
  localparam logic [PN_LEN-1:0] LFSR_SEED     = PN_SEED ^ PN_LEN'(CH_IDX);
  localparam logic [DATA_W-1:0] CHK_A         = CHK_FIRST[DATA_W-1:0];
  localparam logic [DATA_W-1:0] CHK_B         = CHK_SECOND[DATA_W-1:0];

  logic [DATA_W-1:0] ramp, ramp_b;
  logic              phase, phase_b;
  logic [PN_LEN-1:0] lfsr, lfsr_b;

  // A reseed that coincides with a step emits the seed word this cycle
  assign ramp_b  = reseed ? RAMP_SEED : ramp;
  assign phase_b = reseed ? 1'b0      : phase;
  assign lfsr_b  = reseed ? LFSR_SEED : lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ramp  <= RAMP_SEED;
      phase <= 1'b0;
      lfsr  <= LFSR_SEED;
    end else if (step) begin
      ramp  <= ramp_b + DATA_W'(1);
      phase <= ~phase_b;
      lfsr  <= pn_step(lfsr_b);
    end else if (reseed) begin
      ramp  <= RAMP_SEED;
      phase <= 1'b0;
      lfsr  <= LFSR_SEED;
    end
  end

  always_comb begin
    sample = '0;
    case (mode)
      MODE_RAMP:    sample = ramp_b;
      MODE_CHECKER: sample = phase_b ? CHK_B : CHK_A;
      MODE_PN23:    sample = lfsr_b[DATA_W-1:0];
      MODE_FIXED:   sample = fixed_word;
      default:      sample = '0;
    endcase
  end

endmodule

// File: rtl/adc_pattern_gen.sv
// Multi-channel ADC test-pattern generator: IDLE/SYNC_WAIT/RUN sequencer,
// pending-mode handling, registered sample/overrange outputs and DDR split.
module adc_pattern_gen
  import adc_pattern_pkg::*;
#(
  parameter int DATA_W    = 14,
  parameter int NUM_CH    = 2,
  parameter int SYNC_LAT  = 4,
  parameter int CH_OFFSET = 2**(DATA_W-2)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     pdwn,
  input  logic                     sync,
  input  logic [2:0]               mode_i,
  input  logic                     mode_we,
  input  logic [DATA_W-1:0]        fixed_word,
  output logic [NUM_CH*DATA_W-1:0] data_o,
  output logic                     valid_o,
  output logic [NUM_CH-1:0]        or_o,
  output logic [DATA_W-1:0]        ddr_rise_o,
  output logic [DATA_W-1:0]        ddr_fall_o,
  output logic [31:0]              sample_cnt_o
);

  localparam logic [7:0] WAIT_LOAD = 8'(SYNC_LAT - 1);
  localparam int         FALL_CH   = (NUM_CH > 1) ? 1 : 0;

  state_t            state, state_nx;
  logic [7:0]        wait_cnt, wait_nx;
  logic              step, sync_rs, apply, reseed;
  logic [2:0]        act_mode, pend_mode, eff_mode;
  logic              pend_flag;
  logic [DATA_W-1:0] samp [NUM_CH];
  logic [NUM_CH*DATA_W-1:0] data_nx;
  logic [NUM_CH-1:0] or_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_nx;
    end
  end

  // Power-down/disable dominate; sync restarts the wait from any active state
  always_comb begin
    state_nx = state;
    wait_nx  = wait_cnt;
    step     = 1'b0;
    sync_rs  = 1'b0;
    if (pdwn || !en) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          state_nx = SYNC_WAIT;
          wait_nx  = WAIT_LOAD;
        end
        SYNC_WAIT: begin
          if (sync) begin
            wait_nx = WAIT_LOAD;
            sync_rs = 1'b1;
          end else if (wait_cnt == '0) begin
            state_nx = RUN;
            step     = 1'b1;
          end else begin
            wait_nx = wait_cnt - 8'd1;
          end
        end
        RUN: begin
          if (sync) begin
            state_nx = SYNC_WAIT;
            wait_nx  = WAIT_LOAD;
            sync_rs  = 1'b1;
          end else begin
            step = 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  assign apply    = step && pend_flag;
  assign reseed   = sync_rs || apply;
  assign eff_mode = apply ? pend_mode : act_mode;

  // A write landing on the same edge as an apply stays pending for the next one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_mode <= MODE_ZERO;
      pend_flag <= 1'b0;
      act_mode  <= MODE_ZERO;
    end else begin
      if (apply) act_mode <= pend_mode;
      if (mode_we) begin
        pend_mode <= mode_i;
        pend_flag <= 1'b1;
      end else if (apply) begin
        pend_flag <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    adc_pattern_ch #(
      .DATA_W   (DATA_W),
      .CH_IDX   (k),
      .CH_OFFSET(CH_OFFSET)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (eff_mode),
      .reseed    (reseed),
      .step      (step),
      .fixed_word(fixed_word),
      .sample    (samp[k])
    );
  end

  always_comb begin
    data_nx = '0;
    or_nx   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      data_nx[k*DATA_W +: DATA_W] = samp[k];
      or_nx[k] = (samp[k] == '0) || (samp[k] == '1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o      <= 1'b0;
      data_o       <= '0;
      or_o         <= '0;
      sample_cnt_o <= '0;
    end else begin
      valid_o <= step;
      data_o  <= step ? data_nx : '0;
      or_o    <= step ? or_nx : '0;
      if (reseed)
        sample_cnt_o <= step ? 32'd1 : 32'd0;
      else if (step && sample_cnt_o != 32'hFFFF_FFFF)
        sample_cnt_o <= sample_cnt_o + 32'd1;
    end
  end

  assign ddr_rise_o = data_o[0 +: DATA_W];
  assign ddr_fall_o = data_o[FALL_CH*DATA_W +: DATA_W];

endmodule

// File: doc/adc_pattern_gen.md
ADC_PATTERN_GEN -- requirements
Module: adc_pattern_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 14, sample width in bits (legal 8..16).
REQ-002 SHALL have parameter NUM_CH, default 2, channel count (legal 1..8).
REQ-003 SHALL have parameter SYNC_LAT, default 4, cycles from sync pulse to first valid sample (legal 1..255).
REQ-004 SHALL have parameter CH_OFFSET, default 2**(DATA_W-2), ramp start offset per channel index.
REQ-005 Ports:
- clk  in  1  sample clock; one clock; all logic on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  generation enable.
- pdwn  in  1  power-down; overrides en.
- sync  in  1  resynchronise pulse.
- mode_i  in  3  pattern select.
- mode_we  in  1  mode write strobe.
- fixed_word  in  DATA_W  user pattern word.
- data_o  out  NUM_CH*DATA_W  samples; channel k at bits [k*DATA_W +: DATA_W].
- valid_o  out  1  data_o valid.
- or_o  out  NUM_CH  per-channel overrange flag.
- ddr_rise_o  out  DATA_W  channel 0 word (rising phase).
- ddr_fall_o  out  DATA_W  channel 1 word (falling phase); channel 0 when NUM_CH=1.
- sample_cnt_o  out  32  valid samples since last sync/reseed.

Function
REQ-006 Modes: 0 ZERO (all 0), 1 RAMP, 2 CHECKER, 3 PN23, 4 FIXED (fixed_word); codes 5-7 treated as ZERO.
REQ-007 RAMP: channel k seeds to (k*CH_OFFSET) mod 2**DATA_W, +1 per valid sample, wraps max->0.
REQ-008 CHECKER: alternates 0101..01 / 1010..10 (LSB first), first sample after seed = 0101..01 on all channels.
REQ-009 PN23: per-channel LFSR x^23+x^18+1, seed 23'h7FFFFF xor k, one shift per valid sample, output = low DATA_W bits.
REQ-010 FSM states: IDLE, SYNC_WAIT, RUN.
REQ-011 IDLE: entered when pdwn=1 or en=0; valid_o=0, data_o=0, or_o=0, generators hold.
REQ-012 IDLE->SYNC_WAIT when en=1 and pdwn=0; SYNC_WAIT lasts SYNC_LAT cycles with valid_o=0, then ->RUN.
REQ-013 sync=1 in any non-IDLE state: reseed all generators, clear sample_cnt_o, (re)enter SYNC_WAIT with counter reloaded; sync in IDLE ignored.
REQ-014 RUN: one new sample per cycle, valid_o=1; data_o registered, latency 1 cycle from generator state.
REQ-015 mode_we=1 latches mode_i into pending register; applied at next RUN cycle boundary with reseed and sample_cnt_o cleared; mode_we during IDLE/SYNC_WAIT applies before first valid sample.
REQ-016 Simultaneous sync and mode_we: both honoured; new mode active at first valid sample after SYNC_WAIT.
REQ-017 Simultaneous pdwn and sync: pdwn wins, IDLE.
REQ-018 or_o[k]=1 with valid_o when channel k word is all-ones or all-zeros, else 0.
REQ-019 sample_cnt_o increments per valid sample, saturates at 32'hFFFFFFFF.
REQ-020 fixed_word sampled every RUN cycle (changes visible next sample).

Reset
REQ-021 rst_n=0: state IDLE, all outputs 0, pending mode 0 (ZERO), generators at seed values.
REQ-022 Reset mid-RUN: outputs go 0 asynchronously; after release, SYNC_LAT invalid cycles precede first sample.

Structure
REQ-023 Package adc_pattern_pkg SHALL hold mode enum, state enum, PN23 taps/seed constants.
REQ-024 One sub-module adc_pattern_ch (single-channel generator: ramp/checker/PN/fixed), instantiated NUM_CH times.

Verification
REQ-025 Reset, en=1, mode RAMP, DATA_W=14, NUM_CH=2 -> valid_o rises after 4 cycles; ch0 0,1,2..., ch1 4096,4097...; or_o[0]=1 on first sample.
REQ-026 RAMP run 16384 samples -> ch0 wraps 16383->0, or_o[0]=1 at 16383 and 0; sample_cnt_o=16384.
REQ-027 Mode PN23 -> ch0 first 4 samples match reference LFSR from seed 7FFFFF; ch1 from seed 7FFFFE.
REQ-028 sync pulse mid-RUN -> valid_o low 4 cycles, RAMP restarts at 0, sample_cnt_o=0.
REQ-029 pdwn=1 mid-RUN with sync same cycle -> IDLE next cycle, data_o=0; pdwn=0 -> 4 invalid cycles then resume from held generator state.
REQ-030 mode_we FIXED with fixed_word=14'h3FFF -> next sample all channels 3FFF, or_o=all ones; ddr_rise_o=ddr_fall_o=3FFF.
